addr_pipe_u: RTL
================

ADDR_PIPE_U -- requirements
Module: addr_pipe_u

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 Parameter STAGES, default 2: pipeline depth in cycles; legal range 1..4; WIDTH SHALL be divisible by STAGES.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1: operand pair present.
REQ-006 Port in_ready, output, 1: block accepts operands this cycle.
REQ-007 Port a, input, WIDTH: unsigned operand A.
REQ-008 Port b, input, WIDTH: unsigned operand B.
REQ-009 Port out_valid, output, 1: sum present.
REQ-010 Port out_ready, input, 1: consumer accepts sum this cycle.
REQ-011 Port sum, output, WIDTH+1: unsigned A+B; MSB is carry-out.
REQ-012 Port op_count, output, 16: number of completed output transfers, saturating.
REQ-013 Port fault_err, output, 1: sticky lockstep-mismatch flag (see Configuration).

Function
REQ-014 Addition SHALL be carry-pipelined: stage k adds operand slice k (WIDTH/STAGES bits, LSB slice first) plus the registered carry from stage k-1; higher unconsumed slices and finished sum slices SHALL be delayed in skew registers.
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer when out_valid and out_ready are both 1.
REQ-016 Latency from input transfer to out_valid SHALL be exactly STAGES cycles absent backpressure; throughput one result per cycle.
REQ-017 Each stage SHALL carry a valid bit; a stage SHALL advance when it is empty or the next stage advances (bubble-collapsing), the last stage advancing on output transfer.
REQ-018 in_ready SHALL equal "stage 0 can advance" and SHALL NOT combinationally depend on in_valid.
REQ-019 While out_valid=1 and out_ready=0, sum and out_valid SHALL hold stable.
REQ-020 sum SHALL be exact for all inputs, including a=b=2^WIDTH-1 giving sum=2^(WIDTH+1)-2.
REQ-021 op_count SHALL increment by 1 per output transfer and saturate at 16'hFFFF.
REQ-022 Simultaneous input and output transfer with a full pipeline SHALL lose no data and duplicate no result.

Reset
REQ-023 On rst_n=0, all valid bits, skew/carry registers, op_count and fault_err SHALL clear to 0 immediately, regardless of clk.
REQ-024 During reset out_valid=0, sum=0, in_ready=0; in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operands; no partial result SHALL appear after release.

Configuration
REQ-026 Macro ADDR_PIPE_DMR_EN SHALL, when defined, instantiate a second independent datapath fed with the same accepted operands; on each output transfer, mismatch between the two sums SHALL set fault_err, which stays 1 until reset; sum SHALL come from the primary datapath.
REQ-027 Without ADDR_PIPE_DMR_EN, no duplicate logic SHALL exist and fault_err SHALL be tied to 0.

Structure
REQ-028 Package addr_pipe_pkg SHALL hold the op_count width constant (16), the saturation value, and the stage-payload struct typedef (valid, carry, partial sum, remaining operand slices).
REQ-029 One sub-module addr_pipe_stage SHALL implement a single slice-add-and-register stage; addr_pipe_u SHALL chain STAGES instances (and a second chain under ADDR_PIPE_DMR_EN).

Verification
REQ-030 WIDTH=8, STAGES=2: a=8'hFF, b=8'h01, out_ready=1 -> out_valid after 2 cycles, sum=9'h100.
REQ-031 Back-to-back stream of 100 random pairs, out_ready=1 -> 100 correct sums in order, one per cycle, op_count=100.
REQ-032 Hold out_ready=0 for 5 cycles with full pipeline -> in_ready=0, sum stable, then release -> all results in order, none lost.
REQ-033 Assert rst_n=0 mid-stream between clock edges -> out_valid=0 and op_count=0 immediately; after release no stale sum emitted.
REQ-034 With ADDR_PIPE_DMR_EN, force one carry bit in the shadow chain -> fault_err=1 on that output transfer and stays 1; without macro fault_err constant 0.
REQ-035 Sweep WIDTH=16 and STAGES in {1,2,4}, exhaustive carry-chain cases (0+0, all-ones+1, all-ones+all-ones) -> exact sums at latency STAGES.

Source files
------------

// File: rtl/addr_pipe_pkg.sv
// Shared constants and the per-stage payload carried down the carry-pipelined adder.
// Payload fields are sized for the widest legal operand (32 bits); narrower builds leave the top bits zero.
package addr_pipe_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = 16'hFFFF;
  localparam int MAX_W = 32;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [MAX_W:0]   psum;
    logic [MAX_W-1:0] rem_a;
    logic [MAX_W-1:0] rem_b;
  } stage_t;

endpackage

// File: rtl/addr_pipe_stage.sv
// One slice-add-and-register stage: adds the lowest remaining operand slice plus the incoming
// carry, deposits the slice result at its final bit position and shifts the leftover slices down.
module addr_pipe_stage
  import addr_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_adv,
  input  stage_t i_d,
  output stage_t o_q
);

  localparam int SW = WIDTH / STAGES;

  logic [SW:0] w_slice;
  stage_t      w_next;
  stage_t      r_q;

  always_comb begin
    w_slice = {1'b0, i_d.rem_a[SW-1:0]} + {1'b0, i_d.rem_b[SW-1:0]} + {{SW{1'b0}}, i_d.carry};
    w_next       = i_d;
    w_next.carry = w_slice[SW];
    w_next.psum  = i_d.psum | ({{(MAX_W+1-SW){1'b0}}, w_slice[SW-1:0]} << (IDX * SW));
    w_next.rem_a = i_d.rem_a >> SW;
    w_next.rem_b = i_d.rem_b >> SW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_adv) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/addr_pipe_u.sv
// Valid/ready carry-pipelined unsigned adder with saturating transfer counter.
// Define ADDR_PIPE_DMR_EN to add a lockstep shadow datapath that raises sticky fault_err on mismatch.
module addr_pipe_u
  import addr_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic [CNT_W-1:0] op_count,
  output logic             fault_err
);

  stage_t             w_in;
  stage_t             w_pri [0:STAGES];
  logic [STAGES-1:0]  w_adv;
  logic               w_out_xfer;
  logic               w_unused;
  logic               r_run;
  logic [CNT_W-1:0]   r_cnt;

  // Bubble-collapsing advance: a stage moves when empty or when its successor moves.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_pri[STAGES].valid || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = !w_pri[k+1].valid || w_adv[k+1];
    end
  end

  assign in_ready = r_run & w_adv[0];

  always_comb begin
    w_in       = '0;
    w_in.valid = in_valid & in_ready;
    w_in.rem_a = MAX_W'(a);
    w_in.rem_b = MAX_W'(b);
  end

  assign w_pri[0] = w_in;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_pri
      addr_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .IDX(gi)) u_stg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_adv[gi]),
        .i_d   (w_pri[gi]),
        .o_q   (w_pri[gi+1])
      );
    end
  endgenerate

  assign out_valid  = w_pri[STAGES].valid;
  assign sum        = {w_pri[STAGES].carry, w_pri[STAGES].psum[WIDTH-1:0]};
  assign w_out_xfer = out_valid & out_ready;
  assign w_unused   = ^{w_pri[STAGES].rem_a, w_pri[STAGES].rem_b, w_pri[STAGES].psum[MAX_W:WIDTH]};

  // r_run keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_out_xfer && (r_cnt != CNT_SAT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign op_count = r_cnt;

`ifdef ADDR_PIPE_DMR_EN
  stage_t         w_shd_in;
  stage_t         w_shd [0:STAGES];
  logic           w_shd_cin;
  logic [WIDTH:0] w_shd_sum;
  logic           w_shd_unused;
  logic           r_fault;

  assign w_shd_cin = 1'b0;

  always_comb begin
    w_shd_in       = w_in;
    w_shd_in.carry = w_shd_cin;
  end

  assign w_shd[0] = w_shd_in;

  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_shd
      addr_pipe_stage #(.WIDTH(WIDTH), .STAGES(STAGES), .IDX(gi)) u_stg (
        .clk   (clk),
        .rst_n (rst_n),
        .i_adv (w_adv[gi]),
        .i_d   (w_shd[gi]),
        .o_q   (w_shd[gi+1])
      );
    end
  endgenerate

  assign w_shd_sum    = {w_shd[STAGES].carry, w_shd[STAGES].psum[WIDTH-1:0]};
  assign w_shd_unused = ^{w_shd[STAGES].valid, w_shd[STAGES].rem_a, w_shd[STAGES].rem_b,
                          w_shd[STAGES].psum[MAX_W:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (w_out_xfer && (w_shd_sum != sum)) begin
      r_fault <= 1'b1;
    end
  end

  assign fault_err = r_fault;
`else
  assign fault_err = 1'b0;
`endif

endmodule
